matrix_stream_tx: RTL

Host-side sequencer that feeds the 4×4 int8 matrix-multiply engine over its serial load interface and collects its result stream. It accepts one job (16 weight bytes, then 16 feature bytes) from a valid/ready host port and buffers it. It then pulses the engine's reset, bursts both matrices out in 16 cycles, asserts start, and captures the 16 output bytes after a fixed latency. Finally it returns the results to the host over a valid/ready port.

---
 rtl/matrix_stream_pkg.sv | 21 ++
 rtl/matrix_stream_tx_byte_buf16.sv | 25 ++
 rtl/matrix_stream_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_pkg.sv
// Shared state encoding, sizes and helpers for the matrix_stream_tx host sequencer.
package matrix_stream_pkg;

    localparam int DATA_W         = 8;
    localparam int N_ELEM         = 16;
    localparam int RESULT_LAT_DEF = 20;

    typedef enum logic [2:0] {
        LOAD,
        PULSE,
        SEND,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/matrix_stream_tx_byte_buf16.sv
// 16-entry register file, one synchronous write port and one combinational read port.
module byte_buf16 #(
    parameter int DATA_W = matrix_stream_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [3:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [3:0]        i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    import matrix_stream_pkg::*;

    logic [DATA_W-1:0] r_mem [16];

    // Contents survive reset; only the sequencer's control state is cleared.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/matrix_stream_tx.sv
// Host-side load/start/capture sequencer for the 4x4 int8 matmul engine.
// Optional job counter output enabled by defining MATRIX_STREAM_TX_STATS_EN.
module matrix_stream_tx #(
    parameter int DATA_W     = matrix_stream_pkg::DATA_W,
    parameter int N_ELEM     = matrix_stream_pkg::N_ELEM,
    parameter int RESULT_LAT = matrix_stream_pkg::RESULT_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] port_w,
    output logic              we_w,
    output logic [DATA_W-1:0] port_a,
    output logic              we_a,
    output logic              eng_rst,
    output logic              start_o,
    input  logic [DATA_W-1:0] port_o,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef MATRIX_STREAM_TX_STATS_EN
    ,
    output logic [15:0]       job_count
`endif
);
    import matrix_stream_pkg::*;

    localparam int                LAT_W     = $clog2(RESULT_LAT + 1);
    localparam logic [3:0]        ELEM_LAST = 4'(N_ELEM - 1);
    localparam logic [4:0]        LD_LAST   = 5'(2 * N_ELEM - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RESULT_LAT - 1);

    state_t             r_state;
    logic [4:0]         r_ld_cnt;
    logic [3:0]         r_snd_cnt;
    logic [3:0]         r_cap_cnt;
    logic [3:0]         r_rd_cnt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [DATA_W-1:0]  r_port_w;
    logic [DATA_W-1:0]  r_port_a;
    logic               r_we;
    logic               r_eng_rst;
    logic               r_start;
    logic [DATA_W-1:0]  r_out_data;
`ifdef MATRIX_STREAM_TX_STATS_EN
    logic [15:0]        r_job_count;
`endif

    logic               w_accept;
    logic               w_out_fire;
    logic               w_wbuf_we;
    logic               w_fbuf_we;
    logic               w_cap_we;
    logic [3:0]         w_snd_raddr;
    logic [3:0]         w_rd_raddr;
    logic [DATA_W-1:0]  w_wbuf_rdata;
    logic [DATA_W-1:0]  w_fbuf_rdata;
    logic [DATA_W-1:0]  w_rbuf_rdata;

    assign w_accept   = (r_state == LOAD) && in_valid;
    assign w_out_fire = (r_state == DRAIN) && out_ready;
    assign w_wbuf_we  = w_accept && !r_ld_cnt[4];
    assign w_fbuf_we  = w_accept && r_ld_cnt[4];
    assign w_cap_we   = (r_state == CAPTURE);

    // Read one element ahead so the registered engine/host outputs line up with their counters.
    assign w_snd_raddr = (r_state == PULSE) ? 4'd0 : r_snd_cnt + 4'd1;
    assign w_rd_raddr  = (r_state == DRAIN) ? r_rd_cnt + 4'd1 : 4'd0;

    byte_buf16 #(.DATA_W(DATA_W)) u_wbuf (
        .i_clk(clk), .i_we(w_wbuf_we), .i_waddr(r_ld_cnt[3:0]), .i_wdata(in_data),
        .i_raddr(w_snd_raddr), .o_rdata(w_wbuf_rdata)
    );

    byte_buf16 #(.DATA_W(DATA_W)) u_fbuf (
        .i_clk(clk), .i_we(w_fbuf_we), .i_waddr(r_ld_cnt[3:0]), .i_wdata(in_data),
        .i_raddr(w_snd_raddr), .o_rdata(w_fbuf_rdata)
    );

    byte_buf16 #(.DATA_W(DATA_W)) u_rbuf (
        .i_clk(clk), .i_we(w_cap_we), .i_waddr(r_cap_cnt), .i_wdata(port_o),
        .i_raddr(w_rd_raddr), .o_rdata(w_rbuf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LOAD;
            r_ld_cnt   <= '0;
            r_snd_cnt  <= '0;
            r_cap_cnt  <= '0;
            r_rd_cnt   <= '0;
            r_lat_cnt  <= '0;
            r_port_w   <= '0;
            r_port_a   <= '0;
            r_we       <= 1'b0;
            r_eng_rst  <= 1'b0;
            r_start    <= 1'b0;
            r_out_data <= '0;
`ifdef MATRIX_STREAM_TX_STATS_EN
            r_job_count <= '0;
`endif
        end else begin
            r_eng_rst <= 1'b0;
            unique case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (r_ld_cnt == LD_LAST) begin
                            r_ld_cnt  <= '0;
                            r_eng_rst <= 1'b1;
                            r_state   <= PULSE;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + 5'd1;
                        end
                    end
                end
                PULSE: begin
                    r_port_w <= w_wbuf_rdata;
                    r_port_a <= w_fbuf_rdata;
                    r_we     <= 1'b1;
                    r_state  <= SEND;
                end
                SEND: begin
                    if (r_snd_cnt == ELEM_LAST) begin
                        r_snd_cnt <= '0;
                        r_we      <= 1'b0;
                        r_start   <= 1'b1;
                        r_state   <= WAIT;
                    end else begin
                        r_snd_cnt <= r_snd_cnt + 4'd1;
                        r_port_w  <= w_wbuf_rdata;
                        r_port_a  <= w_fbuf_rdata;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_lat_cnt <= '0;
                        r_state   <= CAPTURE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (r_cap_cnt == ELEM_LAST) begin
                        r_cap_cnt  <= '0;
                        r_start    <= 1'b0;
                        r_out_data <= w_rbuf_rdata;
                        r_state    <= DRAIN;
                    end else begin
                        r_cap_cnt <= r_cap_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (r_rd_cnt == ELEM_LAST) begin
                            r_rd_cnt <= '0;
                            r_state  <= LOAD;
`ifdef MATRIX_STREAM_TX_STATS_EN
                            r_job_count <= sat_inc16(r_job_count);
`endif
                        end else begin
                            r_rd_cnt   <= r_rd_cnt + 4'd1;
                            r_out_data <= w_rbuf_rdata;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DRAIN);
    assign busy      = (r_state != LOAD);
    assign port_w    = r_port_w;
    assign port_a    = r_port_a;
    assign we_w      = r_we;
    assign we_a      = r_we;
    assign eng_rst   = r_eng_rst;
    assign start_o   = r_start;
    assign out_data  = r_out_data;
`ifdef MATRIX_STREAM_TX_STATS_EN
    assign job_count = r_job_count;
`endif

endmodule
